// File: rtl/sprom.sv
// Single-port ROM with a registered read, one cycle of latency.
// Holds one period of a signed sine: word k = round((2^(dw-1)-1) * sin(2*pi*k/2^aw)).
module sprom #(
    parameter int    aw            = 10,
    parameter int    dw            = 16,
    parameter string MEM_INIT_FILE = ""
) (
    input  logic          clk_i,
    input  logic [aw-1:0] addr_i,
    output logic [dw-1:0] rdata_o
);

    // Contents are generated at elaboration; a file-based image is not supported.
    if (MEM_INIT_FILE != "") begin : g_no_file
        $error("sprom: MEM_INIT_FILE is not supported, contents are generated");
    end

    function automatic logic [dw-1:0] sine_word(input int k);
        real amp;
        real r;
        amp = real'((1 << (dw - 1)) - 1);
        r   = amp * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(2 ** aw));
        if (r >= 0.0) begin
            return dw'($rtoi(r + 0.5));
        end
        return dw'(-$rtoi(0.5 - r));
    endfunction

    logic [dw-1:0] mem [2**aw];
    logic [dw-1:0] rdata_q;

    always_comb begin
        for (int k = 0; k < 2 ** aw; k++) begin
            mem[k] = sine_word(k);
        end
    end

    always_ff @(posedge clk_i) begin
        rdata_q <= mem[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/iq_downconv.sv
// NCO quadrature downconverter: one real Q1.15 sample in, x*e^{-j*phi} out on an I/Q pair.
// Four-state one-hot FSM with a single sample in flight; phase accumulates per accepted sample.
module iq_downconv #(
    parameter int    lw   = 10,
    parameter string sine = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] x_i,
    input  logic        x_valid_i,
    output logic        x_ready_o,
    input  logic [31:0] phase_inc_i,
    input  logic        phase_clr_i,
    output logic [15:0] y_a_o,
    output logic [15:0] y_b_o,
    output logic        y_valid_o,
    input  logic        y_ready_i
);

    // Handshake: a sample moves on the input when x_valid_i and x_ready_o are both 1,
    // and on the output when y_valid_o and y_ready_i are both 1; valid never waits on ready.
    typedef enum logic [3:0] {
        S_READY = 4'b0001,
        S_LOAD  = 4'b0010,
        S_MUL   = 4'b0100,
        S_DONE  = 4'b1000
    } state_t;

    localparam logic [lw-1:0] QUARTER = lw'(1 << (lw - 2));

    state_t             state_q;
    logic        [31:0] phase_q;
    logic        [31:0] inc_q;
    logic signed [15:0] x_q;
    logic signed [31:0] pa_q;
    logic signed [31:0] pb_q;
    logic               x_ready_q;
    logic               y_valid_q;

    logic        [lw-1:0] sin_addr;
    logic        [lw-1:0] cos_addr;
    logic        [15:0]   sin_word;
    logic        [15:0]   cos_word;
    logic signed [31:0]   pa_d;
    logic signed [31:0]   pb_d;
    logic signed [16:0]   a_sh;
    logic signed [16:0]   b_neg;

    function automatic logic [15:0] sat16(input logic signed [16:0] v);
        if (v > 17'sd32767) begin
            return 16'h7fff;
        end
        if (v < -17'sd32768) begin
            return 16'h8000;
        end
        return v[15:0];
    endfunction

    // cos(phi) = sin(phi + pi/2): a quarter-table offset, wrapping around the period.
    assign sin_addr = phase_q[31 -: lw];
    assign cos_addr = sin_addr + QUARTER;

    sprom #(.aw(lw), .dw(16), .MEM_INIT_FILE(sine)) u_sin_rom (
        .clk_i   (clk),
        .addr_i  (sin_addr),
        .rdata_o (sin_word)
    );

    sprom #(.aw(lw), .dw(16), .MEM_INIT_FILE(sine)) u_cos_rom (
        .clk_i   (clk),
        .addr_i  (cos_addr),
        .rdata_o (cos_word)
    );

    assign pa_d = 32'(x_q) * 32'($signed(cos_word));
    assign pb_d = 32'(x_q) * 32'($signed(sin_word));

    // The Q term is negated at 17 bits so that a full-scale product clamps instead of wrapping.
    assign a_sh  = 17'(pa_q >>> 15);
    assign b_neg = -(17'(pb_q >>> 15));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_READY;
            phase_q   <= '0;
            inc_q     <= '0;
            x_q       <= '0;
            pa_q      <= '0;
            pb_q      <= '0;
            x_ready_q <= 1'b0;
            y_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_READY: begin
                    if (phase_clr_i) begin
                        phase_q <= '0;
                    end
                    if (x_valid_i) begin
                        state_q   <= S_LOAD;
                        x_ready_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    x_q       <= $signed(x_i);
                    inc_q     <= phase_inc_i;
                    x_ready_q <= 1'b0;
                    state_q   <= S_MUL;
                end
                S_MUL: begin
                    pa_q      <= pa_d;
                    pb_q      <= pb_d;
                    phase_q   <= phase_q + inc_q;
                    y_valid_q <= 1'b1;
                    state_q   <= S_DONE;
                end
                S_DONE: begin
                    if (y_ready_i) begin
                        y_valid_q <= 1'b0;
                        state_q   <= S_READY;
                    end
                end
                default: begin
                    state_q   <= S_READY;
                    x_ready_q <= 1'b0;
                    y_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // The products only change on leaving S_MUL, so the outputs hold their last value elsewhere.
    assign y_a_o     = sat16(a_sh);
    assign y_b_o     = sat16(b_neg);
    assign x_ready_o = x_ready_q;
    assign y_valid_o = y_valid_q;

endmodule

// File: tb/tb_iq_downconv.sv
// Directed bench for iq_downconv: quarter-turn phase steps, backpressure, phase clear,
// saturation with both ROM words held at full negative scale, and reset during a multiply.
module tb_iq_downconv;

    logic        clk;
    logic        rst;
    logic [15:0] x_i;
    logic        x_valid_i;
    logic        x_ready_o;
    logic [31:0] phase_inc_i;
    logic        phase_clr_i;
    logic [15:0] y_a_o;
    logic [15:0] y_b_o;
    logic        y_valid_o;
    logic        y_ready_i;

    int n_vec = 0;
    int n_err = 0;

    iq_downconv dut (
        .clk         (clk),
        .rst         (rst),
        .x_i         (x_i),
        .x_valid_i   (x_valid_i),
        .x_ready_o   (x_ready_o),
        .phase_inc_i (phase_inc_i),
        .phase_clr_i (phase_clr_i),
        .y_a_o       (y_a_o),
        .y_b_o       (y_b_o),
        .y_valid_o   (y_valid_o),
        .y_ready_i   (y_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        x_valid_i = 1'b0;
        phase_clr_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Offers one sample from S_READY and checks it through to the first S_DONE cycle.
    task automatic run_sample(input string tag, input logic [15:0] xv, input logic [31:0] incv,
                              input logic clrv, input int ea, input int eb);
        int n;
        @(negedge clk);
        x_i = xv;
        phase_inc_i = incv;
        phase_clr_i = clrv;
        x_valid_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!x_ready_o && n < 8);
        check({tag, ".accept_lat"}, n, 1);
        x_valid_i = 1'b0;
        phase_clr_i = 1'b0;
        @(negedge clk);
        check({tag, ".xrdy_pulse"}, x_ready_o, 0);
        check({tag, ".early_valid"}, y_valid_o, 0);
        @(negedge clk);
        check({tag, ".valid"}, y_valid_o, 1);
        check({tag, ".ya"}, $signed(y_a_o), ea);
        check({tag, ".yb"}, $signed(y_b_o), eb);
    endtask

    initial begin
        rst = 1'b1;
        x_i = '0;
        x_valid_i = 1'b0;
        phase_inc_i = '0;
        phase_clr_i = 1'b0;
        y_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst.valid", y_valid_o, 0);
        check("rst.xrdy", x_ready_o, 0);
        check("rst.ya", $signed(y_a_o), 0);
        check("rst.yb", $signed(y_b_o), 0);
        rst = 1'b0;

        // Zero increment: phase stays at 0, cos = 32767, sin = 0.
        for (int i = 0; i < 3; i++) begin
            run_sample("inc0", 16'd16384, 32'h0, 1'b0, 16383, 0);
        end

        // Quarter-turn steps walk the four cardinal points and wrap past 2^32.
        run_sample("q0", 16'd16384, 32'h4000_0000, 1'b0, 16383, 0);
        run_sample("q1", 16'd16384, 32'h4000_0000, 1'b0, 0, -16383);
        run_sample("q2", 16'd16384, 32'h4000_0000, 1'b0, -16384, 0);
        run_sample("q3", 16'd16384, 32'h4000_0000, 1'b0, 0, 16384);
        run_sample("q4", 16'd16384, 32'h4000_0000, 1'b0, 16383, 0);

        // Backpressure: output must hold and input must stay blocked.
        pulse_reset();
        y_ready_i = 1'b0;
        run_sample("bp", 16'hc000, 32'h0, 1'b0, -16384, 0);
        x_i = 16'd1234;
        x_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp.hold_valid", y_valid_o, 1);
            check("bp.hold_ya", $signed(y_a_o), -16384);
            check("bp.hold_yb", $signed(y_b_o), 0);
            check("bp.hold_xrdy", x_ready_o, 0);
        end
        y_ready_i = 1'b1;
        x_valid_i = 1'b0;
        @(negedge clk);
        check("bp.release_valid", y_valid_o, 0);
        check("bp.release_xrdy", x_ready_o, 0);

        // Phase clear together with the third sample's valid.
        pulse_reset();
        run_sample("clr0", 16'd16384, 32'h4000_0000, 1'b0, 16383, 0);
        run_sample("clr1", 16'd16384, 32'h4000_0000, 1'b0, 0, -16383);
        run_sample("clr2", 16'd16384, 32'h4000_0000, 1'b1, 16383, 0);

        // Both ROM words at -32768 with x = -32768: I clamps, Q lands exactly on -32768.
        pulse_reset();
        @(negedge clk);
        force dut.u_sin_rom.rdata_q = 16'h8000;
        force dut.u_cos_rom.rdata_q = 16'h8000;
        run_sample("sat", 16'h8000, 32'h0, 1'b0, 32767, -32768);
        release dut.u_sin_rom.rdata_q;
        release dut.u_cos_rom.rdata_q;

        // Reset while in S_MUL aborts the sample with no output.
        pulse_reset();
        @(negedge clk);
        x_i = 16'd16384;
        phase_inc_i = 32'h4000_0000;
        x_valid_i = 1'b1;
        for (int n = 0; n < 8 && !x_ready_o; n++) begin
            @(negedge clk);
        end
        check("rstmul.accept", x_ready_o, 1);
        x_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rstmul.no_valid", y_valid_o, 0);
            @(negedge clk);
        end
        check("rstmul.ya_cleared", $signed(y_a_o), 0);
        run_sample("after_rst", 16'd16384, 32'h0, 1'b0, 16383, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/iq_downconv.md
Name: iq_downconv

Overview:
- Quadrature downconverter (NCO mixer) directly upstream of the complex matched-filter stage.
- Takes one real 16-bit sample per handshake and multiplies it by e^{-j*phi[n]}, with phi[n] from a 32-bit phase accumulator.
- Emits a complex sample on an a/b (I/Q) valid/ready interface, matching the filter's x_a_i/x_b_i input.
- Multi-cycle FSM, one sample in flight; throughput is not a requirement.

Parameters:
- lw, 10, log2 of sine-table entries; the table covers one full period.
- sine, "", init file for the sine table: 2^lw signed 16-bit Q1.15 entries, entry k = round(32767*sin(2*pi*k/2^lw)).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- x_i  in  16  real input sample, signed Q1.15.
- x_valid_i  in  1  input sample valid.
- x_ready_o  out  1  input accepted this cycle.
- phase_inc_i  in  32  NCO increment; 2^32 corresponds to one full cycle; sampled on accept.
- phase_clr_i  in  1  synchronous NCO phase clear.
- y_a_o  out  16  I output, signed Q1.15.
- y_b_o  out  16  Q output, signed Q1.15.
- y_valid_o  out  1  output valid.
- y_ready_i  in  1  downstream accepts output.

Behaviour:
- Clocking/reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: state=S_READY, phase=0, y_a_o=0, y_b_o=0, x_ready_o=0, y_valid_o=0.
- Reset mid-operation: aborts any in-flight sample with no output produced. Phase returns to 0.
- States, one-hot: S_READY, S_LOAD, S_MUL, S_DONE.
- S_READY: waits for x_valid_i=1, then goes to S_LOAD. x_valid_i must stay high until accepted.
- S_LOAD:
  - x_ready_o=1 for exactly this cycle.
  - Latch x_i and phase_inc_i.
  - Present ROM addresses: sin at phase[31:32-lw]; cos at phase[31:32-lw] + 2^(lw-2), modulo 2^lw.
  - Next state S_MUL.
- S_MUL:
  - ROM data is valid (synchronous read, 1-cycle latency).
  - Register pa = x*cos and pb = x*sin as full 32-bit signed products.
  - Advance the phase: phase <= phase + inc, wrapping mod 2^32.
  - Next state S_DONE.
- S_DONE:
  - y_valid_o=1.
  - y_a_o = sat16(pa >>> 15); y_b_o = sat16(-(pb >>> 15)). The shift is arithmetic and truncating (floor).
  - Outputs are held stable while y_valid_o=1 and y_ready_i=0.
  - When y_ready_i=1, go to S_READY.
- y_a_o/y_b_o keep their last value outside S_DONE.
- Latency: accept cycle to first y_valid_o cycle is 2 cycles. Minimum period is 4 cycles per sample.
- sat16 clamps to [-32768, 32767]. The negation is done at 17-bit width, so -(-32768) gives +32767.
- phase_clr_i:
  - Honoured only in S_READY; phase <= 0.
  - If it is asserted in the same cycle that x_valid_i moves the FSM to S_LOAD, the accepted sample uses phase 0.
  - Ignored in all other states.
- Phase wrap past 2^32 is silent and continuous.
- Each ROM is a 16-bit sprom instance sharing the same init file.

Decomposition:
- No shared package. State encodings are local parameters, the same way the filter stage defines them.
- Sub-modules: two sprom instances (aw=lw, dw=16, MEM_INIT_FILE=sine).
- A small combinational sat16 function is inlined.
- No further sub-module is warranted.

Test Plan:
- phase_inc_i=0, x_i=16384 repeated 3 times, y_ready_i=1 -> each output (y_a,y_b)=(16383,0); x_ready_o pulses 1 cycle; y_valid_o exactly 2 cycles after the accept.
- phase_inc_i=32'h40000000, x_i=16384 for 5 samples -> (16383,0), (0,-16383), (-16384,0), (0,16384), (16383,0); confirms 32-bit wrap.
- Backpressure: y_ready_i=0 for 10 cycles in S_DONE -> y_valid_o stays 1, y_a/y_b unchanged, x_ready_o stays 0; then y_ready_i=1 -> S_READY next cycle.
- phase_inc_i=32'h40000000, two samples, then phase_clr_i=1 together with x_valid_i in S_READY -> third output is (16383,0), not (-16384,0).
- Saturation, using a test table whose entry 0 is -32768 and x_i=-32768 -> y_a_o=32767 (saturated).
- rst asserted in S_MUL -> no y_valid_o pulse; the next sample with inc=0 outputs (16383,0) for x=16384.
